// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer: issues sequential imem reads and queues (instr, pc) pairs for the core.
// Optional PREFETCH_BYPASS_EN forwards a response straight to the outputs when the FIFO is empty.
module instr_prefetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_en,
    output logic [31:0]                imem_addr,
    input  logic [31:0]                imem_rdata,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [31:0]                out_pc,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam logic [CW:0] DEPTH_OCC = (CW+1)'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   mem_instr_q [DEPTH];
    logic [31:0]   mem_instr_d [DEPTH];
    logic [31:0]   mem_pc_q    [DEPTH];
    logic [31:0]   mem_pc_d    [DEPTH];

    logic [CW:0] occ;
    logic        resp;
    logic        push;
    logic        pop;
    logic        bypass_take;

    always_comb begin
        // Guard counts the outstanding read but never credits a same-cycle pop.
        occ       = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
        imem_en   = !reset && !redirect && (occ < DEPTH_OCC);
        imem_addr = fetch_pc_q;
        resp      = inflight_q && !redirect && !reset;

        out_valid   = (count_q != '0);
        out_instr   = mem_instr_q[rd_ptr_q];
        out_pc      = mem_pc_q[rd_ptr_q];
        bypass_take = 1'b0;
`ifdef PREFETCH_BYPASS_EN
        if (count_q == '0 && resp) begin
            out_valid   = 1'b1;
            out_instr   = imem_rdata;
            out_pc      = inflight_pc_q;
            bypass_take = out_ready;
        end
`endif
        push  = resp && !bypass_take;
        pop   = (count_q != '0) && out_ready && !redirect;
        count = count_q;

        fetch_pc_d    = fetch_pc_q;
        inflight_d    = imem_en;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        mem_instr_d   = mem_instr_q;
        mem_pc_d      = mem_pc_q;

        if (imem_en) begin
            fetch_pc_d    = fetch_pc_q + 32'd1;
            inflight_pc_d = fetch_pc_q;
        end

        if (push) begin
            mem_instr_d[wr_ptr_q] = imem_rdata;
            mem_pc_d[wr_ptr_q]    = inflight_pc_q;
            wr_ptr_d              = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (redirect) begin
            fetch_pc_d = redirect_pc;
            inflight_d = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        mem_instr_q <= mem_instr_d;
        mem_pc_q    <= mem_pc_d;
    end
endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Self-checking bench for instr_prefetch_buffer: queue-based reference model plus scenario tasks.
// Honours PREFETCH_BYPASS_EN so the same bench covers both builds.
module tb_instr_prefetch_buffer;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int unsigned CW       = $clog2(DEPTH+1);
    localparam int unsigned VW       = 98 + CW;
`ifdef PREFETCH_BYPASS_EN
    localparam int REDIR_LAT = 2;
`else
    localparam int REDIR_LAT = 3;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          imem_en;
    logic [31:0]   imem_addr;
    logic [31:0]   imem_rdata;
    logic          redirect = 1'b0;
    logic [31:0]   redirect_pc = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_instr;
    logic [31:0]   out_pc;
    logic [CW-1:0] count;

    int total = 0;
    int bad   = 0;

    instr_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'hA000_0000 + a;
    endfunction

    // Instruction memory: 1-cycle latency, garbage on idle cycles.
    logic        en_s;
    logic [31:0] addr_s;
    always @(negedge clk) begin
        en_s   <= imem_en;
        addr_s <= imem_addr;
    end
    always @(posedge clk) begin
        if (en_s) imem_rdata <= rom(addr_s);
        else      imem_rdata <= $urandom;
    end

    // Reference model: queue of buffered PCs, one outstanding read at most.
    logic [31:0] mq[$];
    bit          m_infl = 1'b0;
    logic [31:0] m_fpc = '0;
    logic [31:0] m_ipc = '0;
    always @(posedge clk) begin
        bit issue;
        bit consumed;
        if (reset) begin
            mq.delete(); m_infl = 1'b0; m_fpc = RESET_PC;
        end else if (redirect) begin
            mq.delete(); m_infl = 1'b0; m_fpc = redirect_pc;
        end else begin
            issue    = (mq.size() + int'(m_infl)) < DEPTH;
            consumed = 1'b0;
            if (out_ready && mq.size() > 0) void'(mq.pop_front());
`ifdef PREFETCH_BYPASS_EN
            else if (out_ready && m_infl) consumed = 1'b1;
`endif
            if (m_infl && !consumed) mq.push_back(m_ipc);
            if (issue) begin
                m_ipc = m_fpc;
                m_fpc = m_fpc + 32'd1;
            end
            m_infl = issue;
        end
    end

    function automatic logic [VW-1:0] exp_vec();
        logic        en, v;
        logic [31:0] hp;
        en = !reset && !redirect && ((mq.size() + int'(m_infl)) < DEPTH);
        v  = mq.size() != 0;
        hp = v ? mq[0] : 32'h0;
`ifdef PREFETCH_BYPASS_EN
        if (!v && m_infl && !redirect && !reset) begin
            v  = 1'b1;
            hp = m_ipc;
        end
`endif
        return {en, en ? m_fpc : 32'h0, v, v ? hp : 32'h0, v ? rom(hp) : 32'h0, CW'(mq.size())};
    endfunction

    function automatic logic [VW-1:0] act_vec();
        return {imem_en, imem_en ? imem_addr : 32'h0, out_valid,
                out_valid ? out_pc : 32'h0, out_valid ? out_instr : 32'h0, count};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            reset = 1'b1; redirect = 1'b0; out_ready = 1'b0;
            @(negedge clk);
            total++;
            if (imem_en !== 1'b0 || out_valid !== 1'b0 || count !== '0) begin
                bad++;
                $display("FAIL reset_outputs: en=%b valid=%b count=%0d want 0 0 0", imem_en, out_valid, count);
            end
        end
    endtask

    task automatic test_fill();
        logic [31:0] issued[$];
        logic [11:0] en_hist;
        bit ok;
        for (int c = 0; c < 12; c++) begin
            step();
            reset = 1'b0; out_ready = 1'b0;
            @(negedge clk);
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++; $display("FAIL fill_model: got %h want %h", act_vec(), exp_vec());
            end
            en_hist[c] = imem_en;
            if (imem_en) issued.push_back(imem_addr);
        end
        total++;
        if (en_hist !== 12'h00F) begin
            bad++; $display("FAIL fill_issue_pattern: got %b want %b", en_hist, 12'h00F);
        end
        ok = issued.size() == 4;
        for (int i = 0; i < issued.size() && i < 4; i++)
            if (issued[i] !== RESET_PC + 32'(i)) ok = 1'b0;
        total++;
        if (!ok) begin
            bad++; $display("FAIL fill_addresses: got %0d issues (first %h) want 4 from %h",
                            issued.size(), issued.size() > 0 ? issued[0] : 32'hx, RESET_PC);
        end
        total++;
        if (count !== CW'(DEPTH)) begin
            bad++; $display("FAIL fill_count: got %0d want %0d", count, DEPTH);
        end
    endtask

    task automatic test_drain();
        logic [31:0] exp_pc = RESET_PC;
        for (int c = 0; c < 20; c++) begin
            step();
            out_ready = 1'b1;
            @(negedge clk);
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++; $display("FAIL drain_model: got %h want %h", act_vec(), exp_vec());
            end
            if (c >= 4) begin
                total++;
                if (out_valid !== 1'b1) begin
                    bad++; $display("FAIL drain_gap: cycle %0d valid=%b want 1", c, out_valid);
                end
            end
            if (out_valid) begin
                total++;
                if (out_pc !== exp_pc || out_instr !== rom(exp_pc)) begin
                    bad++; $display("FAIL drain_seq: got pc=%h instr=%h want pc=%h instr=%h",
                                    out_pc, out_instr, exp_pc, rom(exp_pc));
                end
                exp_pc = exp_pc + 32'd1;
            end
        end
    endtask

    task automatic test_redirect_inflight();
        bit found = 1'b0;
        int first = -1;
        for (int c = 0; c < 30 && !found; c++) begin
            step();
            if (mq.size() == 2 && m_infl) found = 1'b1;
            else begin
                out_ready = 1'b1;
                @(negedge clk);
            end
        end
        total++;
        if (!found) begin
            bad++; $display("FAIL redir_setup: count=2 with read in flight not reached, got count=%0d want 2", count);
        end
        redirect = 1'b1; redirect_pc = 32'h40; out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (act_vec() !== exp_vec() || imem_en !== 1'b0) begin
            bad++; $display("FAIL redir_T: got %h want %h", act_vec(), exp_vec());
        end
        for (int k = 1; k <= 8; k++) begin
            step();
            redirect = 1'b0;
            @(negedge clk);
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++; $display("FAIL redir_model: got %h want %h", act_vec(), exp_vec());
            end
            if (k == 1) begin
                total++;
                if (imem_en !== 1'b1 || imem_addr !== 32'h40) begin
                    bad++; $display("FAIL redir_issue: got en=%b addr=%h want 1 00000040", imem_en, imem_addr);
                end
            end
            if (out_valid && first < 0) begin
                first = k;
                total++;
                if (out_pc !== 32'h40 || out_instr !== rom(32'h40)) begin
                    bad++; $display("FAIL redir_first_entry: got pc=%h instr=%h want 00000040 %h",
                                    out_pc, out_instr, rom(32'h40));
                end
            end
        end
        total++;
        if (first != REDIR_LAT) begin
            bad++; $display("FAIL redir_latency: got %0d want %0d", first, REDIR_LAT);
        end
    endtask

    task automatic test_redirect_pop();
        logic [31:0] rpc = $urandom;
        bit got = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            out_ready = 1'b0;
            @(negedge clk);
        end
        step();
        redirect = 1'b1; redirect_pc = rpc; out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || act_vec() !== exp_vec()) begin
            bad++; $display("FAIL pop_collide_T: got %h want %h", act_vec(), exp_vec());
        end
        step();
        redirect = 1'b0; out_ready = 1'($urandom_range(1));
        @(negedge clk);
        total++;
        if (count !== '0 || act_vec() !== exp_vec()) begin
            bad++; $display("FAIL pop_collide_flush: got count=%0d want 0 (vec %h want %h)", count, act_vec(), exp_vec());
        end
        for (int c = 0; c < 20 && !got; c++) begin
            if (out_valid && out_ready) begin
                got = 1'b1;
                total++;
                if (out_pc !== rpc || out_instr !== rom(rpc)) begin
                    bad++; $display("FAIL pop_collide_next: got pc=%h want %h", out_pc, rpc);
                end
            end
            step();
            out_ready = 1'($urandom_range(1));
            @(negedge clk);
        end
        total++;
        if (!got) begin
            bad++; $display("FAIL pop_collide_timeout: got no delivery want pc=%h", rpc);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] seen[$];
        logic [31:0] want [4];
        bit ok = 1'b1;
        want[0] = 32'hFFFF_FFFE; want[1] = 32'hFFFF_FFFF; want[2] = 32'h0; want[3] = 32'h1;
        step();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE; out_ready = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 15 && seen.size() < 4; c++) begin
            step();
            redirect = 1'b0;
            @(negedge clk);
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++; $display("FAIL wrap_model: got %h want %h", act_vec(), exp_vec());
            end
            if (out_valid) seen.push_back(out_pc);
        end
        if (seen.size() != 4) ok = 1'b0;
        for (int i = 0; i < seen.size() && i < 4; i++) if (seen[i] !== want[i]) ok = 1'b0;
        total++;
        if (!ok) begin
            bad++; $display("FAIL wrap_seq: got %0d pcs (first %h) want fffffffe ffffffff 0 1",
                            seen.size(), seen.size() > 0 ? seen[0] : 32'hx);
        end
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        bit got = 1'b0;
        step();
        redirect = 1'b1; redirect_pc = 32'h1234; out_ready = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 20 && !found; c++) begin
            step();
            if (mq.size() == 3 && m_infl) found = 1'b1;
            else begin
                redirect = 1'b0; out_ready = 1'b0;
                @(negedge clk);
            end
        end
        total++;
        if (!found || count !== CW'(3)) begin
            bad++; $display("FAIL rst_mid_setup: got count=%0d want 3", count);
        end
        reset = 1'b1;
        @(negedge clk);
        step();
        reset = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || count !== '0) begin
            bad++; $display("FAIL rst_mid_clear: got valid=%b count=%0d want 0 0", out_valid, count);
        end
        for (int c = 0; c < 10 && !got; c++) begin
            if (out_valid) begin
                got = 1'b1;
                total++;
                if (out_pc !== RESET_PC || out_instr !== rom(RESET_PC)) begin
                    bad++; $display("FAIL rst_mid_first: got pc=%h want %h", out_pc, RESET_PC);
                end
            end
            step();
            @(negedge clk);
        end
        total++;
        if (!got) begin
            bad++; $display("FAIL rst_mid_timeout: got no delivery want pc=%h", RESET_PC);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            step();
            reset       = ($urandom_range(99) == 0);
            redirect    = ($urandom_range(19) == 0);
            redirect_pc = $urandom;
            out_ready   = 1'($urandom_range(1));
            @(negedge clk);
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++; $display("FAIL random_model: cycle %0d got %h want %h", c, act_vec(), exp_vec());
            end
        end
        step();
        reset = 1'b0; redirect = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_redirect_inflight();
        test_redirect_pop();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
